// File: rtl/mux8_rr_arbiter_if.sv
// mux8_rr_arbiter_if: request/grant/select bundle between requesters and the mux arbiter
interface mux8_rr_arbiter_if;
  logic [7:0] req;
  logic [7:0] grant;
  logic S0;
  logic S1;
  logic S2;
  logic busy;
  modport master(output req, input grant, S0, S1, S2, busy);
  modport slave(input req, output grant, S0, S1, S2, busy);
endinterface

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin arbiter driving the 8:1 mux select lines
module mux8_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input logic clk,
  input logic rst,
  mux8_rr_arbiter_if.slave bus
);
  typedef enum logic {IDLE, OWN} state_t;
  localparam logic [7:0] MAX = 8'(MAX_HOLD);
  state_t state, state_n;
  logic [2:0] ptr, ptr_n, sel, sel_n, base, nxt;
  logic [7:0] grant, grant_n, hold_cnt, hold_n, cand;
  logic found, sat;
  // in OWN the scan starts after the owner and excludes it; sel doubles as owner index
  always_comb begin
    sat = hold_cnt >= MAX;
    cand = state == IDLE ? bus.req : bus.req & ~(8'b1 << sel);
    base = state == IDLE ? ptr : sel + 3'd1;
    found = 1'b0;
    nxt = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (cand[base + 3'(i)]) begin
        found = 1'b1;
        nxt = base + 3'(i);
      end
  end
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    sel_n = sel;
    grant_n = grant;
    hold_n = hold_cnt;
    if (state == OWN && (!bus.req[sel] || (sat && found))) begin
      ptr_n = sel + 3'd1;
      state_n = IDLE;
      grant_n = 8'h00;
    end else if (state == OWN)
      hold_n = sat ? MAX : hold_cnt + 8'd1;
    if (found && (state == IDLE || !bus.req[sel] || sat)) begin
      state_n = OWN;
      grant_n = 8'b1 << nxt;
      sel_n = nxt;
      hold_n = 8'd1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ptr <= 3'd0;
      sel <= 3'd0;
      grant <= 8'h00;
      hold_cnt <= 8'd0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      sel <= sel_n;
      grant <= grant_n;
      hold_cnt <= hold_n;
    end
  assign bus.grant = grant;
  assign {bus.S2, bus.S1, bus.S0} = sel;
  assign bus.busy = |grant;
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter: directed and random checks of the round-robin mux arbiter
module tb_mux8_rr_arbiter;
  logic clk = 1'b0;
  logic rst;
  int vectors = 0;
  int miscompares = 0;
  int wt [8];
  logic [2:0] last;
  mux8_rr_arbiter_if bus();
  mux8_rr_arbiter #(.MAX_HOLD(4)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] s_val();
    return {5'd0, bus.S2, bus.S1, bus.S0};
  endfunction
  function automatic logic [2:0] idx(input logic [7:0] g);
    logic [2:0] r = 3'd0;
    for (int i = 0; i < 8; i++) if (g[i]) r = 3'(i);
    return r;
  endfunction
  initial begin
    rst = 1'b1;
    bus.req = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk("rst_grant", bus.grant, 8'h00);
    chk("rst_sel", s_val(), 8'h00);
    chk("rst_busy", {7'd0, bus.busy}, 8'h00);
    rst = 1'b0;
    bus.req = 8'hFF;
    @(negedge clk);
    chk("first_grant", bus.grant, 8'h01);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_grant", bus.grant, 8'h00);
    chk("async_sel", s_val(), 8'h00);
    chk("async_busy", {7'd0, bus.busy}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_grant", bus.grant, 8'h01);
    bus.req = 8'h00;
    @(negedge clk);
    chk("release_idle", bus.grant, 8'h00);
    bus.req = 8'h20;
    @(negedge clk);
    chk("single_grant", bus.grant, 8'h20);
    chk("single_sel", s_val(), 8'h05);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("single_hold", bus.grant, 8'h20);
    end
    bus.req = 8'h00;
    @(negedge clk);
    chk("single_drop", bus.grant, 8'h00);
    chk("sel_kept", s_val(), 8'h05);
    chk("idle_busy", {7'd0, bus.busy}, 8'h00);
    rst = 1'b1;
    #1 rst = 1'b0;
    bus.req = 8'h81;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("rr_grant", bus.grant, ((k / 4) % 2) != 0 ? 8'h80 : 8'h01);
      chk("rr_sel", s_val(), ((k / 4) % 2) != 0 ? 8'h07 : 8'h00);
    end
    bus.req = 8'h00;
    @(negedge clk);
    @(negedge clk);
    bus.req = 8'h04;
    @(negedge clk);
    chk("b2b_owner", bus.grant, 8'h04);
    bus.req = 8'h40;
    @(negedge clk);
    chk("b2b_grant", bus.grant, 8'h40);
    chk("b2b_sel", s_val(), 8'h06);
    chk("b2b_busy", {7'd0, bus.busy}, 8'h01);
    bus.req = 8'h08;
    @(negedge clk);
    chk("late_owner", bus.grant, 8'h08);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("late_alone", bus.grant, 8'h08);
    end
    bus.req = 8'h0A;
    @(negedge clk);
    chk("late_preempt", bus.grant, 8'h02);
    chk("late_sel", s_val(), 8'h01);
    last = 3'd1;
    for (int i = 0; i < 8; i++) wt[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      int mx;
      @(negedge clk);
      mx = 0;
      chk("onehot", {7'd0, $onehot0(bus.grant)}, 8'h01);
      chk("busy", {7'd0, bus.busy}, {7'd0, |bus.grant});
      if (|bus.grant) last = idx(bus.grant);
      chk("sel_index", s_val(), {5'd0, last});
      for (int i = 0; i < 8; i++) begin
        wt[i] = (bus.req[i] && !bus.grant[i]) ? wt[i] + 1 : 0;
        if (wt[i] > mx) mx = wt[i];
      end
      chk("starve", {7'd0, mx <= 36}, 8'h01);
      for (int i = 0; i < 8; i++)
        if (bus.req[i] && bus.grant[i] && $urandom_range(3) == 0) bus.req[i] = 1'b0;
        else if (!bus.req[i] && $urandom_range(2) == 0) bus.req[i] = 1'b1;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
